// File: rtl/pipe_wb_buf_if.sv
// pipe_wb_buf_if: MEM->WB writeback buffer bus.
// Carries the MEM push side, the WB pop handshake, the flush and the occupancy.
// "master" is the MEM/WB side; "slave" is the buffer itself.
interface pipe_wb_buf_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic          in_wb_e;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_idx;
    logic          flush;
    logic          buf_avail;
    logic          buf_re;
    logic          buf_rack;
    logic          wb_e;
    logic [DW-1:0] dout;
    logic [AW-1:0] idxout;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_wb_e, in_data, in_idx, flush, buf_re,
        input  in_ready, buf_avail, buf_rack, wb_e, dout, idxout, count
    );

    modport slave (
        input  in_valid, in_wb_e, in_data, in_idx, flush, buf_re,
        output in_ready, buf_avail, buf_rack, wb_e, dout, idxout, count
    );
endinterface

// File: rtl/pipe_wb_buf.sv
// pipe_wb_buf: elastic MEM->WB buffer.
// Queues {wb_e, data, idx} records from MEM in a circular array and hands them
// to WB one at a time over buf_avail / buf_re / buf_rack. A pop loads the
// output registers and raises buf_rack for exactly one cycle, so WB sees at
// most one record every two cycles even with buf_re held high.
// Optional feature: define PIPE_WB_BUF_BYPASS_EN to let a record arriving at
// an empty buffer go straight to the output registers when WB is asking.
module pipe_wb_buf #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    pipe_wb_buf_if.slave      bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = 1 + DW + AW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          rack_q;
    logic          wbe_q;
    logic [DW-1:0] dout_q;
    logic [AW-1:0] idx_q;

    logic          full;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [RW-1:0] head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr];

    assign bus.in_ready  = !full;
    assign bus.buf_avail = !empty;
    assign bus.count     = count_q;
    assign bus.buf_rack  = rack_q;
    assign bus.wb_e      = wbe_q;
    assign bus.dout      = dout_q;
    assign bus.idxout    = idx_q;

    // Decide this cycle's push, pop and (optionally) bypass; flush overrides all.
    always_comb begin
        bypass = 1'b0;
`ifdef PIPE_WB_BUF_BYPASS_EN
        bypass = empty && bus.in_valid && bus.buf_re && !rack_q && !bus.flush;
`else
        bypass = 1'b0;
`endif
        push = bus.in_valid && !full && !bus.flush && !bypass;
        pop  = bus.buf_re && !empty && !rack_q && !bus.flush;
    end

    // Record storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_wb_e, bus.in_data, bus.in_idx};
        end
    end

    // Pointers and occupancy; flush empties the queue by catching rd_ptr up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Output registers load on pop or bypass and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rack_q <= 1'b0;
            wbe_q  <= 1'b0;
            dout_q <= '0;
            idx_q  <= '0;
        end else begin
            rack_q <= pop || bypass;
            if (pop) begin
                {wbe_q, dout_q, idx_q} <= head;
            end else if (bypass) begin
                {wbe_q, dout_q, idx_q} <= {bus.in_wb_e, bus.in_data, bus.in_idx};
            end
        end
    end

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_CNT);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));
`endif
endmodule

// File: tb/tb_pipe_wb_buf.sv
// tb_pipe_wb_buf: directed, table-driven bench for pipe_wb_buf (DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_pipe_wb_buf;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic        in_valid;
        logic        in_wb_e;
        logic [31:0] in_data;
        logic [4:0]  in_idx;
        logic        flush;
        logic        buf_re;
        logic [2:0]  e_count;
        logic        e_rack;
        logic        e_ready;
        logic        e_avail;
        logic        e_wbe;
        logic [31:0] e_dout;
        logic [4:0]  e_idx;
    } vec_t;

    vec_t vecs[$];

    pipe_wb_buf_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

    pipe_wb_buf #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] c, input logic rk,
                               input logic rdy, input logic av, input logic wbe,
                               input logic [31:0] d, input logic [4:0] ix);
        check_output({tag, ".count"},     32'(bus.count),     32'(c));
        check_output({tag, ".buf_rack"},  32'(bus.buf_rack),  32'(rk));
        check_output({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
        check_output({tag, ".buf_avail"}, 32'(bus.buf_avail), 32'(av));
        check_output({tag, ".wb_e"},      32'(bus.wb_e),      32'(wbe));
        check_output({tag, ".dout"},      bus.dout,           d);
        check_output({tag, ".idxout"},    32'(bus.idxout),    32'(ix));
    endtask

    task automatic apply_stimulus(input logic iv, input logic we, input logic [31:0] d,
                                  input logic [4:0] ix, input logic fl, input logic re);
        bus.in_valid = iv;
        bus.in_wb_e  = we;
        bus.in_data  = d;
        bus.in_idx   = ix;
        bus.flush    = fl;
        bus.buf_re   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic iv, input logic we, input logic [31:0] d,
                           input logic [4:0] ix, input logic fl, input logic re,
                           input logic [2:0] c, input logic rk, input logic rdy,
                           input logic av, input logic wbe, input logic [31:0] ed,
                           input logic [4:0] eix);
        vec_t v;
        v.in_valid = iv;  v.in_wb_e = we;  v.in_data = d;   v.in_idx = ix;
        v.flush    = fl;  v.buf_re  = re;  v.e_count = c;   v.e_rack = rk;
        v.e_ready  = rdy; v.e_avail = av;  v.e_wbe   = wbe; v.e_dout = ed;
        v.e_idx    = eix;
        vecs.push_back(v);
    endtask

    initial begin
        logic        pw;
        logic [31:0] pd;
        logic [4:0]  pi;

        bus.in_valid = 1'b0;
        bus.in_wb_e  = 1'b0;
        bus.in_data  = '0;
        bus.in_idx   = '0;
        bus.flush    = 1'b0;
        bus.buf_re   = 1'b0;

        // Power-up reset
        #1 rst = 1'b1;
        #2 check_state("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        #9 rst = 1'b0;

        // Single record with buf_re held high
        apply_stimulus(1'b1, 1'b1, 32'hAA, 5'd5, 1'b0, 1'b1);
`ifdef PIPE_WB_BUF_BYPASS_EN
        check_state("t2_e1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hAA, 5'd5);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("t2_e2", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, 5'd5);
`else
        check_state("t2_e1", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("t2_e2", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hAA, 5'd5);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("t2_e3", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, 5'd5);
`endif
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check_state("t2_idle", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, 5'd5);

        // Fill past full, drain in order, then a wb_e=0 record
        //       iv  we  data      idx  fl  re    cnt rk rdy av  wbe dout     idx
        add_vec(1, 1, 32'h1,    5'd1, 0, 0,   3'd1, 0, 1, 1,  1, 32'hAA,   5'd5);
        add_vec(1, 1, 32'h2,    5'd2, 0, 0,   3'd2, 0, 1, 1,  1, 32'hAA,   5'd5);
        add_vec(1, 1, 32'h3,    5'd3, 0, 0,   3'd3, 0, 1, 1,  1, 32'hAA,   5'd5);
        add_vec(1, 1, 32'h4,    5'd4, 0, 0,   3'd4, 0, 0, 1,  1, 32'hAA,   5'd5);
        add_vec(1, 1, 32'h5,    5'd5, 0, 0,   3'd4, 0, 0, 1,  1, 32'hAA,   5'd5);
        add_vec(1, 1, 32'h5,    5'd5, 0, 1,   3'd3, 1, 1, 1,  1, 32'h1,    5'd1);
        add_vec(1, 1, 32'h5,    5'd5, 0, 1,   3'd4, 0, 0, 1,  1, 32'h1,    5'd1);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd3, 1, 1, 1,  1, 32'h2,    5'd2);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd3, 0, 1, 1,  1, 32'h2,    5'd2);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd2, 1, 1, 1,  1, 32'h3,    5'd3);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd2, 0, 1, 1,  1, 32'h3,    5'd3);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd1, 1, 1, 1,  1, 32'h4,    5'd4);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd1, 0, 1, 1,  1, 32'h4,    5'd4);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd0, 1, 1, 0,  1, 32'h5,    5'd5);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd0, 0, 1, 0,  1, 32'h5,    5'd5);
        add_vec(1, 0, 32'h1234, 5'd7, 0, 0,   3'd1, 0, 1, 1,  1, 32'h5,    5'd5);
        add_vec(0, 0, 32'h0,    5'd0, 0, 1,   3'd0, 1, 1, 0,  0, 32'h1234, 5'd7);
        add_vec(0, 0, 32'h0,    5'd0, 0, 0,   3'd0, 0, 1, 0,  0, 32'h1234, 5'd7);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].in_valid, vecs[i].in_wb_e, vecs[i].in_data,
                           vecs[i].in_idx, vecs[i].flush, vecs[i].buf_re);
            check_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_rack,
                        vecs[i].e_ready, vecs[i].e_avail, vecs[i].e_wbe,
                        vecs[i].e_dout, vecs[i].e_idx);
        end

        // Wrap-around: push one, pop one, ten times
        pw = 1'b0;
        pd = 32'h1234;
        pi = 5'd7;
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 1'b1, 32'h100 + 32'(k), 5'(k + 8), 1'b0, 1'b0);
            check_state($sformatf("wrap%0d_push", k), 3'd1, 1'b0, 1'b1, 1'b1, pw, pd, pi);
            apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
            pw = 1'b1;
            pd = 32'h100 + 32'(k);
            pi = 5'(k + 8);
            check_state($sformatf("wrap%0d_pop", k), 3'd0, 1'b1, 1'b1, 1'b0, pw, pd, pi);
        end

        // Flush with three queued records, a push and a read request
        apply_stimulus(1'b1, 1'b1, 32'hA1, 5'd1, 1'b0, 1'b0);
        check_state("fl_p1", 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b1, 1'b1, 32'hA2, 5'd2, 1'b0, 1'b0);
        check_state("fl_p2", 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b1, 1'b1, 32'hA3, 5'd3, 1'b0, 1'b0);
        check_state("fl_p3", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b1, 1'b1, 32'hDEAD, 5'd9, 1'b1, 1'b1);
        check_state("fl_flush", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("fl_after", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b1, 1'b1, 32'hBEEF, 5'd3, 1'b0, 1'b0);
        check_state("fl_push", 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h109, 5'd17);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("fl_pop", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBEEF, 5'd3);

        // Reset in the middle of traffic: count=3 with buf_rack high
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 1'b1, 32'h51 + 32'(k), 5'(k + 20), 1'b0, 1'b0);
        end
        check_state("mid_full", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBEEF, 5'd3);
        apply_stimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        check_state("mid_pop", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h51, 5'd20);
        bus.buf_re = 1'b0;
        rst = 1'b1;
        #1;
        check_state("mid_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        #2 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
